uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a FIFO of outgoing words feeding a start/data/parity/stop
// serializer with a rounded integer baud divider.
module uart_tx_buffered #(
  parameter int CLK_SPEED  = 100_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_req,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_overflow,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          txd
);

  localparam int DIV   = (CLK_SPEED + BAUDRATE / 2) / BAUDRATE;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_next;
  logic [DIV_W-1:0]     baud_cnt, baud_next;
  logic [2:0]           bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par_bit, par_next;
  logic                 txd_next, done_next;
  logic                 pop, push, fifo_empty, baud_end;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [DATA_BITS-1:0] head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_level = count;
  assign push       = tx_req && !fifo_full;
  assign head       = mem[rd_ptr];
  assign baud_end   = (baud_cnt == DIV_LAST);
  assign tx_busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // A write seen while full is dropped even if the serializer pops in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      tx_overflow <= tx_req && fifo_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      par_bit  <= par_next;
      txd      <= txd_next;
      tx_done  <= done_next;
    end
  end

  // txd is registered from the next-state decision so each level lasts exactly DIV cycles.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    par_next   = par_bit;
    txd_next   = txd;
    done_next  = 1'b0;
    pop        = 1'b0;
    if (state != IDLE) baud_next = baud_cnt + 1'b1;
    unique case (state)
      IDLE: begin
        txd_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head;
          par_next   = (^head) ^ (PARITY == 1);
          baud_next  = '0;
          txd_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = shift[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_next = '0;
            if (PARITY != 0) begin
              txd_next   = par_bit;
              state_next = PAR;
            end else begin
              txd_next   = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_next   = bit_cnt + 1'b1;
            shift_next = shift >> 1;
            txd_next   = shift[1];
          end
        end
      end
      PAR: begin
        if (baud_end) begin
          baud_next  = '0;
          bit_next   = '0;
          txd_next   = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_next   = '0;
            done_next  = 1'b1;
            txd_next   = 1'b1;
            state_next = IDLE;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three framing configurations share one stimulus stream
// and are compared every cycle against a frame-level queue model.
module tb_uart_tx_buffered;

  localparam int CLK_SPEED = 1_600_000;
  localparam int BAUDRATE  = 100_000;
  localparam int DIV       = 16;
  localparam int NCFG      = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_req;

  logic [NCFG-1:0] obs_txd, obs_busy, obs_done, obs_ovf, obs_full;
  logic [7:0]      obs_level [NCFG];

  int checks = 0;
  int fails  = 0;
  int ovf_seen [NCFG];

  // Reference state: per configuration, the queued words and the frame on the line.
  logic [7:0] mq [NCFG][$];
  logic [7:0] cur_word [NCFG];
  bit         act [NCFG];
  int         pos [NCFG];
  bit         exp_done [NCFG];
  bit         exp_ovf [NCFG];

  always #5 clk = ~clk;

  // cfg0: 8N1 depth 4, cfg1: 7E1 depth 8, cfg2: 8O2 depth 4
  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    localparam int DB    = (g == 1) ? 7 : 8;
    localparam int PAR   = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    localparam int STOPB = (g == 2) ? 2 : 1;
    localparam int DEPTH = (g == 1) ? 8 : 4;
    logic [$clog2(DEPTH):0] lvl;
    uart_tx_buffered #(
      .CLK_SPEED(CLK_SPEED), .BAUDRATE(BAUDRATE), .DATA_BITS(DB),
      .PARITY(PAR), .STOP_BITS(STOPB), .FIFO_DEPTH(DEPTH)
    ) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data[DB-1:0]), .tx_req(tx_req),
      .fifo_full(obs_full[g]), .fifo_level(lvl), .tx_overflow(obs_ovf[g]),
      .tx_busy(obs_busy[g]), .tx_done(obs_done[g]), .txd(obs_txd[g])
    );
    assign obs_level[g] = 8'(lvl);
  end

  function automatic int cfgDb(int g);
    return (g == 1) ? 7 : 8;
  endfunction

  function automatic int cfgPar(int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 1);
  endfunction

  function automatic int cfgStop(int g);
    return (g == 2) ? 2 : 1;
  endfunction

  function automatic int cfgDepth(int g);
    return (g == 1) ? 8 : 4;
  endfunction

  function automatic int frameBits(int g);
    return 1 + cfgDb(g) + ((cfgPar(g) != 0) ? 1 : 0) + cfgStop(g);
  endfunction

  // Line level of bit 'idx' of the frame carrying word w.
  function automatic logic frameBit(int g, logic [7:0] w, int idx);
    int ones;
    ones = 0;
    if (idx == 0) return 1'b0;
    if (idx <= cfgDb(g)) return w[idx-1];
    if (cfgPar(g) != 0 && idx == cfgDb(g) + 1) begin
      for (int i = 0; i < cfgDb(g); i++) ones += int'(w[i]);
      if (cfgPar(g) == 2) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic modelReset();
    for (int g = 0; g < NCFG; g++) begin
      mq[g].delete();
      cur_word[g] = 8'h00;
      act[g]      = 1'b0;
      pos[g]      = 0;
      exp_done[g] = 1'b0;
      exp_ovf[g]  = 1'b0;
    end
  endtask

  // One clock edge: finish/advance the frame, pop in an idle cycle, then enqueue.
  task automatic modelStep();
    for (int g = 0; g < NCFG; g++) begin
      int  flen;
      bit  pop_now;
      bit  ovf;
      logic [7:0] mask;
      flen        = frameBits(g) * DIV;
      mask        = 8'hFF >> (8 - cfgDb(g));
      exp_done[g] = act[g] && (pos[g] == flen - 1);
      ovf         = tx_req && (mq[g].size() == cfgDepth(g));
      exp_ovf[g]  = ovf;
      pop_now     = !act[g] && (mq[g].size() > 0);
      if (act[g]) begin
        pos[g]++;
        if (pos[g] == flen) act[g] = 1'b0;
      end
      if (pop_now) begin
        cur_word[g] = mq[g].pop_front();
        act[g]      = 1'b1;
        pos[g]      = 0;
      end
      if (tx_req && !ovf) mq[g].push_back(tx_data & mask);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    for (int g = 0; g < NCFG; g++) begin
      logic exp_txd;
      exp_txd = act[g] ? frameBit(g, cur_word[g], pos[g] / DIV) : 1'b1;
      checkOutput($sformatf("cfg%0d txd", g), obs_txd[g], exp_txd);
      checkOutput($sformatf("cfg%0d busy", g), obs_busy[g], act[g]);
      checkOutput($sformatf("cfg%0d done", g), obs_done[g], exp_done[g]);
      checkOutput($sformatf("cfg%0d overflow", g), obs_ovf[g], exp_ovf[g]);
      checkOutput($sformatf("cfg%0d level", g), obs_level[g], mq[g].size());
      checkOutput($sformatf("cfg%0d full", g), obs_full[g], mq[g].size() == cfgDepth(g));
      if (obs_ovf[g]) ovf_seen[g]++;
    end
  endtask

  // Called at a falling edge: drive inputs, step the model at the rising edge,
  // compare on the following falling edge.
  task automatic applyStimulus(input logic req, input logic [7:0] data);
    tx_req  = req;
    tx_data = data;
    @(posedge clk);
    if (reset) modelReset();
    else modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic randomTraffic(input int n, input int pct);
    for (int i = 0; i < n; i++)
      applyStimulus($urandom_range(0, 99) < pct, 8'($urandom));
  endtask

  initial begin
    int k;
    int first_low;
    reset   = 1'b1;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    modelReset();
    @(negedge clk);
    checkAll();
    idleCycles(2);
    reset = 1'b0;

    // Single 0x55 write: line falls two cycles after the write, done at +162.
    applyStimulus(1'b1, 8'h55);
    k = 1;
    first_low = -1;
    while (!obs_done[0] && k < 400) begin
      applyStimulus(1'b0, 8'h00);
      k++;
      if (first_low < 0 && obs_txd[0] == 1'b0) first_low = k;
    end
    checkOutput("cfg0 txd fall latency", first_low, 2);
    checkOutput("cfg0 done latency", k, 162);
    idleCycles(60);

    // Six back-to-back writes against depth-4 FIFOs: exactly one word dropped.
    for (int g = 0; g < NCFG; g++) ovf_seen[g] = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'hA1 + 8'(i));
    idleCycles(1100);
    checkOutput("cfg0 overflow pulses", ovf_seen[0], 1);
    checkOutput("cfg1 overflow pulses", ovf_seen[1], 0);
    checkOutput("cfg2 overflow pulses", ovf_seen[2], 1);
    checkOutput("cfg0 drained level", obs_level[0], 0);

    randomTraffic(2000, 40);
    randomTraffic(1500, 2);
    idleCycles(1800);

    // Reset 50 cycles into a frame of 0x00 with three words still queued.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h00);
    idleCycles(48);
    checkOutput("cfg0 level before reset", obs_level[0], 3);
    #3 reset = 1'b1;
    #1;
    checkOutput("cfg0 txd during reset", obs_txd[0], 1);
    checkOutput("cfg0 level during reset", obs_level[0], 0);
    checkOutput("cfg0 busy during reset", obs_busy[0], 0);
    modelReset();
    @(negedge clk);
    checkAll();
    idleCycles(2);
    reset = 1'b0;
    idleCycles(300);

    randomTraffic(1500, 15);
    idleCycles(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
